pipeline_issue_ctrl: RTL and testbench

Instruction issue unit that feeds the two-phase `pipeline_ALU` datapath from the control side. It accepts packed instruction words over a valid/ready handshake, buffers them in a small FIFO, and detects read-after-write hazards against results still in flight. It issues `rs1/rs2/rd/func/addr` to the pipeline one instruction per `clk1` cycle, and inserts bubbles so that no instruction reads a register before its producer has written it back.

---
 rtl/pipeline_issue_ctrl.sv | 168 ++++++++++++++++
 tb/tb_pipeline_issue_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/pipeline_issue_ctrl.sv
// Instruction issue unit: FIFO-buffered instruction words, RAW hazard bubbles, one issue per clk1.
// Optional build macro: ISSUE_HAZARD_EN enables the in-flight table and hazard stalls.
module pipeline_issue_ctrl #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned WB_LAT = 3
) (
    input  logic        clk1,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [23:0] in_instr,
    output logic [3:0]  rs1,
    output logic [3:0]  rs2,
    output logic [3:0]  rd,
    output logic [3:0]  func,
    output logic [7:0]  addr,
    output logic        issue_valid,
    output logic        stall,
    output logic [15:0] issued_cnt,
    output logic [15:0] hazard_cnt
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned IW    = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        STALL = 2'b10
    } state_e;

    state_e              state_q, state_d;
    logic [IW-1:0]       fifo_q [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                in_ready_q, in_ready_d;
    logic [IW-1:0]       out_q, out_d;
    logic [15:0]         issued_cnt_q, issued_cnt_d;
    logic [15:0]         hazard_cnt_q, hazard_cnt_d;

    logic [IW-1:0]       head_c;
    logic                not_empty_c;
    logic                push_c;
    logic                issue_fire_c;
    logic                hazard_c;

    assign head_c      = fifo_q[rd_ptr_q];
    assign not_empty_c = (count_q != '0);
    assign push_c      = in_valid && in_ready_q;

`ifdef ISSUE_HAZARD_EN
    // An entry that has been in flight WB_LAT-1 cycles is written back by the next edge,
    // so only the younger WB_LAT-1 issues can block the head.
    localparam int unsigned TBL_N = (WB_LAT > 1) ? WB_LAT - 1 : 1;

    logic [TBL_N-1:0] tbl_vld_q, tbl_vld_d;
    logic [3:0]       tbl_rd_q [TBL_N];
    logic [3:0]       tbl_rd_d [TBL_N];
    logic             hit_c;

    always_comb begin
        hit_c = 1'b0;
        for (int unsigned i = 0; i < TBL_N; i++) begin
            if ((WB_LAT > 1) && tbl_vld_q[i] &&
                ((tbl_rd_q[i] == head_c[15:12]) || (tbl_rd_q[i] == head_c[11:8]))) begin
                hit_c = 1'b1;
            end
        end
    end

    assign hazard_c = not_empty_c && hit_c;

    always_comb begin
        tbl_vld_d    = tbl_vld_q;
        tbl_rd_d     = tbl_rd_q;
        tbl_vld_d[0] = issue_fire_c;
        tbl_rd_d[0]  = head_c[19:16];
        for (int unsigned i = 1; i < TBL_N; i++) begin
            tbl_vld_d[i] = tbl_vld_q[i-1];
            tbl_rd_d[i]  = tbl_rd_q[i-1];
        end
    end

    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            tbl_vld_q <= '0;
            for (int unsigned i = 0; i < TBL_N; i++) begin
                tbl_rd_q[i] <= '0;
            end
        end else begin
            tbl_vld_q <= tbl_vld_d;
            tbl_rd_q  <= tbl_rd_d;
        end
    end
`else
    assign hazard_c = 1'b0;
`endif

    // Next state and issue decision; the head issues whenever it is present and unblocked.
    always_comb begin
        state_d      = IDLE;
        issue_fire_c = 1'b0;
        out_d        = out_q;
        issued_cnt_d = issued_cnt_q;
        hazard_cnt_d = hazard_cnt_q;
        if (not_empty_c) begin
            if (hazard_c) begin
                state_d      = STALL;
                hazard_cnt_d = hazard_cnt_q + 16'd1;
            end else begin
                state_d      = ISSUE;
                issue_fire_c = 1'b1;
                out_d        = head_c;
                issued_cnt_d = issued_cnt_q + 16'd1;
            end
        end
    end

    // FIFO pointer and occupancy; in_ready reflects the occupancy after this edge.
    always_comb begin
        wr_ptr_d   = wr_ptr_q + PTR_W'(push_c);
        rd_ptr_d   = rd_ptr_q + PTR_W'(issue_fire_c);
        count_d    = count_q + CNT_W'(push_c) - CNT_W'(issue_fire_c);
        in_ready_d = (count_d != CNT_W'(DEPTH));
    end

    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            in_ready_q   <= 1'b1;
            out_q        <= '0;
            issued_cnt_q <= '0;
            hazard_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            in_ready_q   <= in_ready_d;
            out_q        <= out_d;
            issued_cnt_q <= issued_cnt_d;
            hazard_cnt_q <= hazard_cnt_d;
        end
    end

    always_ff @(posedge clk1) begin
        if (push_c) begin
            fifo_q[wr_ptr_q] <= in_instr;
        end
    end

    assign in_ready    = in_ready_q;
    assign func        = out_q[23:20];
    assign rd          = out_q[19:16];
    assign rs1         = out_q[15:12];
    assign rs2         = out_q[11:8];
    assign addr        = out_q[7:0];
    assign issue_valid = (state_q == ISSUE);
    assign stall       = (state_q == STALL);
    assign issued_cnt  = issued_cnt_q;
    assign hazard_cnt  = hazard_cnt_q;

endmodule

// File: tb/tb_pipeline_issue_ctrl.sv
// Testbench for pipeline_issue_ctrl: directed scenarios plus random traffic against a
// register-ready-time reference model. Follows the ISSUE_HAZARD_EN setting of the build.
module tb_pipeline_issue_ctrl;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned WB_LAT = 3;
`ifdef ISSUE_HAZARD_EN
    localparam bit HZ_EN = 1'b1;
`else
    localparam bit HZ_EN = 1'b0;
`endif

    logic        clk1 = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_instr;
    logic [3:0]  rs1, rs2, rd, func;
    logic [7:0]  addr;
    logic        issue_valid, stall;
    logic [15:0] issued_cnt, hazard_cnt;

    always #5 clk1 = ~clk1;

    pipeline_issue_ctrl #(.DEPTH(DEPTH), .WB_LAT(WB_LAT)) dut (
        .clk1(clk1), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .rs1(rs1), .rs2(rs2), .rd(rd), .func(func), .addr(addr),
        .issue_valid(issue_valid), .stall(stall),
        .issued_cnt(issued_cnt), .hazard_cnt(hazard_cnt)
    );

    // Reference model: queue of pending words and the edge at which each register is readable.
    logic [23:0] mq [$];
    int          ready_at [16];
    int          edge_n = 0;
    logic [23:0] m_out;
    bit          m_iv, m_st, last_acc;
    logic [15:0] m_ic, m_hc;

    int errors = 0;
    int checks = 0;

    function automatic logic [23:0] mk(input int f, input int d, input int s1, input int s2, input int a);
        return {4'(f), 4'(d), 4'(s1), 4'(s2), 8'(a)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    task automatic step();
        logic [23:0] h;
        bit          acc;
        acc = 1'b0;
        if (!rst_n) begin
            mq.delete();
            foreach (ready_at[i]) ready_at[i] = 0;
            m_out = '0; m_iv = 0; m_st = 0; m_ic = '0; m_hc = '0;
        end else begin
            acc  = in_valid && (mq.size() != DEPTH);
            m_iv = 0;
            m_st = 0;
            if (mq.size() > 0) begin
                h = mq[0];
                if (!HZ_EN || (edge_n >= ready_at[h[15:12]] && edge_n >= ready_at[h[11:8]])) begin
                    m_out = h;
                    m_iv  = 1;
                    m_ic  = m_ic + 16'd1;
                    ready_at[h[19:16]] = edge_n + int'(WB_LAT);
                    void'(mq.pop_front());
                end else begin
                    m_st = 1;
                    m_hc = m_hc + 16'd1;
                end
            end
            if (acc) mq.push_back(in_instr);
        end
        last_acc = acc;
        @(posedge clk1);
        edge_n++;
        #1;
        chk("issue_valid", 32'(issue_valid), 32'(m_iv));
        chk("stall", 32'(stall), 32'(m_st));
        chk("fields", 32'({func, rd, rs1, rs2, addr}), 32'(m_out));
        chk("in_ready", 32'(in_ready), 32'(mq.size() != DEPTH));
        chk("issued_cnt", 32'(issued_cnt), 32'(m_ic));
        chk("hazard_cnt", 32'(hazard_cnt), 32'(m_hc));
    endtask

    task automatic push(input logic [23:0] w);
        int n;
        in_valid = 1'b1;
        in_instr = w;
        n = 0;
        do begin
            step();
            n++;
        end while (!last_acc && n < 20);
        chk("push_accept_bound", 32'(last_acc), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout at edge %0d", edge_n);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ic0, hc0;
        int          first_ic;

        // Reset held two cycles with a word offered.
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_instr = mk(1, 10, 3, 5, 8'h11);
        step();
        step();
        chk("reset_issued", 32'(issued_cnt), 32'd0);
        rst_n = 1'b1;
        idle(2);
        chk("post_reset_ready", 32'(in_ready), 32'd1);

        // Independent stream: three issues back to back, one cycle after first accept.
        ic0 = issued_cnt; hc0 = hazard_cnt;
        push(mk(1, 10, 3, 5, 8'h20));
        chk("indep_first_latency", 32'(issue_valid), 32'd0);
        push(mk(3, 12, 3, 8, 8'h21));
        chk("indep_issue1", 32'(issue_valid), 32'd1);
        push(mk(5, 13, 7, 3, 8'h22));
        idle(6);
        chk("indep_issued", 32'(issued_cnt - ic0), 32'd3);
        chk("indep_hazards", 32'(hazard_cnt - hc0), 32'd0);

        // RAW: SUB waits WB_LAT-1 bubbles on ADD; a second reader after it does not stall.
        ic0 = issued_cnt; hc0 = hazard_cnt;
        push(mk(1, 10, 3, 5, 8'h30));
        push(mk(2, 14, 10, 5, 8'h31));
        push(mk(2, 15, 10, 5, 8'h32));
        idle(8);
        chk("raw_issued", 32'(issued_cnt - ic0), 32'd3);
        chk("raw_hazards", 32'(hazard_cnt - hc0), HZ_EN ? 32'(WB_LAT - 1) : 32'd0);

        // Full FIFO: dependent chain keeps the head stalled while words pile up.
        push(mk(1, 1, 8, 9, 8'h40));
        push(mk(1, 2, 1, 9, 8'h41));
        push(mk(1, 3, 2, 9, 8'h42));
        push(mk(4, 4, 8, 9, 8'h43));
        push(mk(4, 5, 8, 9, 8'h44));
        push(mk(4, 6, 8, 9, 8'h45));
        push(mk(4, 7, 8, 9, 8'h46));
        idle(12);

        // Reset while stalled with entries buffered; nothing stale may issue afterwards.
        push(mk(1, 2, 8, 9, 8'h50));
        push(mk(1, 3, 2, 9, 8'h51));
        push(mk(1, 4, 3, 9, 8'h52));
        push(mk(1, 5, 3, 9, 8'h53));
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        idle(3);
        chk("rst_mid_no_issue", 32'(issued_cnt), 32'd0);
        first_ic = 0;
        push(mk(6, 9, 11, 12, 8'h60));
        idle(1);
        chk("rst_mid_new_issue", 32'(issued_cnt), 32'(first_ic + 1));
        idle(2);

        // Random traffic on a small register set to provoke frequent hazards.
        for (int c = 0; c < 400; c++) begin
            in_valid = 1'($urandom_range(0, 3) != 0);
            in_instr = mk($urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 3),
                          $urandom_range(0, 3), $urandom_range(0, 255));
            if (c == 200) rst_n = 1'b0;
            step();
            rst_n = 1'b1;
        end
        idle(12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
